// File: rtl/calc_pkg.sv
// calc_pkg: shared operation select type and default datapath width for the calculator result path
package calc_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam int DEFAULT_WIDTH = 6;

endpackage

// File: rtl/result_pipe_formatter_if.sv
// result_pipe_formatter_if: upstream/downstream handshake and data bundle of the result formatter
interface result_pipe_formatter_if #(
    parameter int N = calc_pkg::DEFAULT_WIDTH
) ();
    import calc_pkg::*;

    logic         in_valid;
    logic         in_ready;
    op_t          op;
    logic [N-1:0] add_res;
    logic [N-1:0] sub_res;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] res;
    logic         is_negative;
    logic         is_min;

    modport master (
        output in_valid, op, add_res, sub_res, out_ready,
        input  in_ready, out_valid, res, is_negative, is_min
    );

    modport slave (
        input  in_valid, op, add_res, sub_res, out_ready,
        output in_ready, out_valid, res, is_negative, is_min
    );

endinterface

// File: rtl/magnitude_negate.sv
// magnitude_negate: two's-complement negation of an N-bit value plus a most-negative detector
module magnitude_negate #(
    parameter int N = calc_pkg::DEFAULT_WIDTH
) (
    input  logic [N-1:0] a_i,
    output logic [N-1:0] mag_o,
    output logic         min_o
);

    // invert-plus-one; -2^(N-1) wraps to itself, which read unsigned is exactly 2^(N-1)
    always_comb begin
        mag_o = ~a_i + {{(N-1){1'b0}}, 1'b1};
        min_o = a_i[N-1] & ~|a_i[N-2:0];
    end

endmodule

// File: rtl/result_pipe_formatter.sv
// result_pipe_formatter: two-stage valid/ready pipe selecting add/sub result and emitting sign-magnitude
module result_pipe_formatter
    import calc_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    result_pipe_formatter_if.slave  bus
);

    logic         s1_valid_q, s1_valid_d;
    logic         s2_valid_q, s2_valid_d;
    logic [N-1:0] s1_data_q, s1_data_d;
    logic [N-1:0] res_q, res_d;
    logic         neg_q, neg_d;
    logic         min_q, min_d;
    logic         s1_ready, s2_ready;
    logic         s1_load, s2_load;
    logic [N-1:0] intr;
    logic [N-1:0] neg_mag;
    logic         intr_min;

    // ready chain runs backwards from the consumer; in_valid never feeds in_ready
    always_comb begin
        s2_ready     = !s2_valid_q || bus.out_ready;
        s1_ready     = !s1_valid_q || s2_ready;
        bus.in_ready = s1_ready;
    end

    // operand selection at the pipe entry
    always_comb begin
        intr = (bus.op == OP_SUB) ? bus.sub_res : bus.add_res;
    end

    magnitude_negate #(.N(N)) u_negate (
        .a_i   (s1_data_q),
        .mag_o (neg_mag),
        .min_o (intr_min)
    );

    // next state: clear wins over every transfer and only touches the valid bits
    always_comb begin
        s1_load    = s1_ready && bus.in_valid && !clear;
        s2_load    = s2_ready && s1_valid_q && !clear;
        s1_valid_d = clear ? 1'b0 : (s1_ready ? bus.in_valid : s1_valid_q);
        s2_valid_d = clear ? 1'b0 : (s2_ready ? s1_valid_q : s2_valid_q);
        s1_data_d  = s1_load ? intr : s1_data_q;
        neg_d      = s2_load ? s1_data_q[N-1] : neg_q;
        res_d      = s2_load ? (s1_data_q[N-1] ? neg_mag : s1_data_q) : res_q;
        min_d      = s2_load ? intr_min : min_q;
    end

    // pipeline state; reset drops all valids and clears the visible result immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_data_q  <= '0;
            res_q      <= '0;
            neg_q      <= 1'b0;
            min_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_data_q  <= s1_data_d;
            res_q      <= res_d;
            neg_q      <= neg_d;
            min_q      <= min_d;
        end
    end

    // outputs come straight from stage-2 registers
    always_comb begin
        bus.out_valid   = s2_valid_q;
        bus.res         = res_q;
        bus.is_negative = neg_q;
        bus.is_min      = min_q;
    end

endmodule

// File: tb/tb_result_pipe_formatter.sv
// tb_result_pipe_formatter: directed vector table plus stream, stall, clear and reset sequences
module tb_result_pipe_formatter;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    result_pipe_formatter_if #(.N(6)) bus ();

    result_pipe_formatter #(.N(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_t        op;
        logic [5:0] add;
        logic [5:0] sub;
        int         res;
        int         neg;
        int         min;
    } vec_t;

    vec_t       vt[8];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [5:0] vals[16];
    logic       ops[16];
    int         n_src, idx, outs, cyc, first_out, last_out, ready_low;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [5:0] v);
        int s;
        int m;
        logic [7:0] r;
        s = int'($signed(v));
        m = (s < 0) ? -s : s;
        r = {(s == -32) ? 1'b1 : 1'b0, (s < 0) ? 1'b1 : 1'b0, 6'(m)};
        return r;
    endfunction

    task automatic edge1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        logic [7:0] e;
        bus.in_valid = idx < n_src;
        if (idx < n_src) begin
            bus.op      = ops[idx] ? OP_SUB : OP_ADD;
            bus.add_res = ops[idx] ? 6'h15 : vals[idx];
            bus.sub_res = ops[idx] ? vals[idx] : 6'h2A;
        end
        #1;
        if (bus.in_valid && !bus.in_ready) ready_low++;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_res", int'(bus.res), int'(e[5:0]));
                chk("stream_neg", int'(bus.is_negative), int'(e[6]));
                chk("stream_min", int'(bus.is_min), int'(e[7]));
            end
            outs++;
            if (outs == 1) first_out = cyc;
            last_out = cyc;
        end
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(vals[idx]));
            idx++;
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.in_valid = 1'b0;
    endtask

    task automatic restart_stream(input int n);
        n_src = n; idx = 0; outs = 0; ready_low = 0; first_out = -1; last_out = -1;
        exp_q.delete();
    endtask

    initial begin
        logic [5:0] held;
        int guard;
        cyc = 0;
        vt[0] = '{OP_ADD, 6'b000101, 6'b101010, 5, 0, 0};
        vt[1] = '{OP_SUB, 6'b010101, 6'b111101, 3, 1, 0};
        vt[2] = '{OP_SUB, 6'b000111, 6'b100000, 32, 1, 1};
        vt[3] = '{OP_ADD, 6'b011111, 6'b100000, 31, 0, 0};
        vt[4] = '{OP_ADD, 6'b000000, 6'b111111, 0, 0, 0};
        vt[5] = '{OP_ADD, 6'b111111, 6'b000001, 1, 1, 0};
        vt[6] = '{OP_SUB, 6'b100000, 6'b100001, 31, 1, 0};
        vt[7] = '{OP_ADD, 6'b100000, 6'b011111, 32, 1, 1};
        bus.in_valid = 1'b0; bus.op = OP_ADD; bus.add_res = '0; bus.sub_res = '0; bus.out_ready = 1'b1;
        n_src = 0; idx = 0;

        #12;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_res", int'(bus.res), 0);
        chk("rst_neg", int'(bus.is_negative), 0);
        chk("rst_min", int'(bus.is_min), 0);
        rst_n = 1'b1;
        edge1();
        chk("rst_in_ready", int'(bus.in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            bus.op = vt[i].op; bus.add_res = vt[i].add; bus.sub_res = vt[i].sub; bus.in_valid = 1'b1;
            #1;
            chk("vec_in_ready", int'(bus.in_ready), 1);
            edge1();
            bus.in_valid = 1'b0;
            chk("vec_latency_ov", int'(bus.out_valid), 0);
            edge1();
            chk("vec_out_valid", int'(bus.out_valid), 1);
            chk("vec_res", int'(bus.res), vt[i].res);
            chk("vec_neg", int'(bus.is_negative), vt[i].neg);
            chk("vec_min", int'(bus.is_min), vt[i].min);
            edge1();
            chk("vec_drained", int'(bus.out_valid), 0);
        end

        for (int i = 0; i < 16; i++) begin
            vals[i] = 6'(i * 7 + 35);
            ops[i]  = i[0];
        end
        restart_stream(8);
        guard = 0;
        while (outs < 8 && guard < 40) begin tick(); guard++; end
        chk("stream_count", outs, 8);
        chk("stream_consecutive", last_out - first_out, 7);
        chk("stream_in_ready_low", ready_low, 0);
        chk("stream_queue_empty", exp_q.size(), 0);

        restart_stream(5);
        bus.out_ready = 1'b0;
        tick();
        tick();
        held = bus.res;
        chk("stall_out_valid", int'(bus.out_valid), 1);
        chk("stall_first_res", int'(bus.res), int'(exp_q[0][5:0]));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_res_stable", int'(bus.res), int'(held));
        end
        chk("stall_accepts", idx, 2);
        bus.in_valid = 1'b1;
        #1;
        chk("stall_in_ready", int'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (outs < 5 && guard < 40) begin tick(); guard++; end
        chk("stall_delivered", outs, 5);
        chk("stall_all_accepted", idx, 5);
        chk("stall_queue_empty", exp_q.size(), 0);

        restart_stream(2);
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("clr_pre_out_valid", int'(bus.out_valid), 1);
        clear = 1'b1;
        bus.in_valid = 1'b1; bus.op = OP_ADD; bus.add_res = 6'd9;
        edge1();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_out_valid", int'(bus.out_valid), 0);
        chk("clr_in_ready", int'(bus.in_ready), 1);
        exp_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("clr_no_stale", outs, 0);

        restart_stream(6);
        vals[0] = 6'b100011; vals[1] = 6'b110000; vals[2] = 6'b100000;
        tick();
        tick();
        chk("arst_pre_valid", int'(bus.out_valid), 1);
        chk("arst_pre_neg", int'(bus.is_negative), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_res", int'(bus.res), 0);
        chk("arst_neg", int'(bus.is_negative), 0);
        chk("arst_min", int'(bus.is_min), 0);
        edge1();
        #3;
        rst_n = 1'b1;
        edge1();
        exp_q.delete();
        n_src = idx;
        outs = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("arst_no_output", outs, 0);
        restart_stream(1);
        vals[0] = 6'b111000;
        for (int i = 0; i < 4; i++) tick();
        chk("arst_restart_outs", outs, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
